// File: rtl/led_drv_pkg.sv
// Shared definitions for the LED pattern driver: load-FSM encoding, width defaults
// and the blink period helper.
package led_drv_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } load_state_t;

  localparam int DEFAULT_NLED     = 6;
  localparam int DEFAULT_PWM_BITS = 8;

  // Blink half-period in clock cycles, never less than one cycle.
  function automatic int blink_cyc_calc(input int clk_hz, input int blink_ms);
    int cyc;
    cyc = clk_hz / 1000 * blink_ms;
    return (cyc < 1) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running blink phase generator: phase toggles every BLINK_CYC clock cycles.
module blink_timer #(
  parameter int BLINK_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  output logic phase
);

  localparam int CW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// Frame-synchronous PWM/blink LED driver with a valid/ready config port.
// Optional breathe ramp is built when LED_DRV_BREATHE_EN is defined.
module led_pattern_driver
  import led_drv_pkg::*;
#(
  parameter int CLK_HZ     = 27_000_000,
  parameter int NLED       = DEFAULT_NLED,
  parameter int PWM_BITS   = DEFAULT_PWM_BITS,
  parameter int BLINK_MS   = 250,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NLED-1:0]     in_pattern,
  input  logic [PWM_BITS-1:0] in_duty,
  input  logic                in_blink,
  input  logic                in_breathe,
  output logic [NLED-1:0]     led,
  output logic                frame_tick
);

  localparam int BLINK_CYC = blink_cyc_calc(CLK_HZ, BLINK_MS);
  localparam logic [NLED-1:0] LED_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_max;
  logic                blink_phase;

  load_state_t         state;
  logic [NLED-1:0]     shadow_pattern, act_pattern;
  logic [PWM_BITS-1:0] shadow_duty, act_duty;
  logic                shadow_blink, act_blink;
  logic [PWM_BITS-1:0] eff_duty;
  logic                pwm_on;
  logic [NLED-1:0]     lit;

  assign pwm_max = (pwm_cnt == '1);

  blink_timer #(.BLINK_CYC(BLINK_CYC)) u_blink (
    .clk   (clk),
    .rst   (rst),
    .phase (blink_phase)
  );

  // Configs land in the shadow first and only reach the active set on the last
  // cycle of a frame, so a frame is always rendered with one consistent config.
`ifdef LED_DRV_BREATHE_EN
  logic shadow_breathe, act_breathe;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      in_ready       <= 1'b1;
      shadow_pattern <= '0;
      shadow_duty    <= '0;
      shadow_blink   <= 1'b0;
      act_pattern    <= '0;
      act_duty       <= '0;
      act_blink      <= 1'b0;
`ifdef LED_DRV_BREATHE_EN
      shadow_breathe <= 1'b0;
      act_breathe    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shadow_pattern <= in_pattern;
            shadow_duty    <= in_duty;
            shadow_blink   <= in_blink;
`ifdef LED_DRV_BREATHE_EN
            shadow_breathe <= in_breathe;
`endif
            state    <= ST_PENDING;
            in_ready <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (pwm_max) begin
            act_pattern <= shadow_pattern;
            act_duty    <= shadow_duty;
            act_blink   <= shadow_blink;
`ifdef LED_DRV_BREATHE_EN
            act_breathe <= shadow_breathe;
`endif
            state    <= ST_IDLE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef LED_DRV_BREATHE_EN
  // Triangle ramp 0..act_duty..0, one step per frame, restarted on every apply.
  logic [PWM_BITS-1:0] bduty;
  logic                ramp_down;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bduty     <= '0;
      ramp_down <= 1'b0;
    end else if (pwm_max) begin
      if (state == ST_PENDING) begin
        bduty     <= '0;
        ramp_down <= 1'b0;
      end else if (!ramp_down) begin
        if (bduty >= act_duty) begin
          ramp_down <= 1'b1;
          bduty     <= (bduty == '0) ? '0 : bduty - 1'b1;
        end else begin
          bduty <= bduty + 1'b1;
        end
      end else begin
        if (bduty == '0) begin
          ramp_down <= 1'b0;
          bduty     <= (act_duty == '0) ? '0 : PWM_BITS'(1);
        end else begin
          bduty <= bduty - 1'b1;
        end
      end
    end
  end

  assign eff_duty = act_breathe ? bduty : act_duty;
`else
  logic unused_breathe;
  assign unused_breathe = in_breathe;
  assign eff_duty       = act_duty;
`endif

  always_comb begin
    pwm_on = (eff_duty == '1) || (pwm_cnt < eff_duty);
    lit    = act_pattern & {NLED{pwm_on & (~act_blink | blink_phase)}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt    <= '0;
      frame_tick <= 1'b0;
      led        <= LED_OFF;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      frame_tick <= pwm_max;
      led        <= (ACTIVE_LOW != 0) ? ~lit : lit;
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed self-checking bench for led_pattern_driver (PWM_BITS=4, BLINK_CYC=20, active-low).
module tb_led_pattern_driver;

  localparam int NLED     = 6;
  localparam int PWM_BITS = 4;
  localparam int FRAME    = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [NLED-1:0]     in_pattern = '0;
  logic [PWM_BITS-1:0] in_duty = '0;
  logic                in_blink = 1'b0;
  logic                in_breathe = 1'b0;
  logic [NLED-1:0]     led;
  logic                frame_tick;

  int checks = 0;
  int errors = 0;
  int cyc;

  led_pattern_driver #(
    .CLK_HZ     (1000),
    .NLED       (NLED),
    .PWM_BITS   (PWM_BITS),
    .BLINK_MS   (20),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pattern (in_pattern),
    .in_duty    (in_duty),
    .in_blink   (in_blink),
    .in_breathe (in_breathe),
    .led        (led),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; pwm position is cyc % FRAME, blink period is 20.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pwm(input int p);
    do @(negedge clk); while ((cyc % FRAME) != p);
  endtask

  task automatic applyStimulus(input logic [NLED-1:0] pat, input logic [PWM_BITS-1:0] duty,
                               input logic blink, input logic breathe);
    checkOutput("ready_before_load", in_ready, 1);
    in_valid   = 1'b1;
    in_pattern = pat;
    in_duty    = duty;
    in_blink   = blink;
    in_breathe = breathe;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("ready_after_load", in_ready, 0);
  endtask

  function automatic logic blink_phase_at(input int k);
    return ((k / 20) % 2) == 0;
  endfunction

`ifdef LED_DRV_BREATHE_EN
  int bexp [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    step(5);
    rst = 1'b0;
    checkOutput("reset_led", led, 6'b111111);
    checkOutput("reset_ready", in_ready, 1);
    checkOutput("reset_tick", frame_tick, 0);
    step(15);
    checkOutput("tick_cyc15", frame_tick, 0);
    step(1);
    checkOutput("tick_cyc16", frame_tick, 1);
    checkOutput("idle_led", led, 6'b111111);
    step(1);
    checkOutput("tick_cyc17", frame_tick, 0);

    $display("[TB] full-duty pattern load mid-frame");
    wait_pwm(5);
    applyStimulus(6'b000101, 4'd15, 1'b0, 1'b0);
    wait_pwm(15);
    checkOutput("pending_ready", in_ready, 0);
    step(1);
    checkOutput("applied_ready", in_ready, 1);
    checkOutput("boundary_led_old", led, 6'b111111);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      checkOutput("full_duty_led", led, 6'b111010);
    end

    $display("[TB] duty 4 on all LEDs");
    wait_pwm(3);
    applyStimulus(6'b111111, 4'd4, 1'b0, 1'b0);
    wait_pwm(0);
    checkOutput("duty4_boundary_old", led, 6'b111010);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      checkOutput("duty4_led", led, ((i - 1) < 4) ? 6'b000000 : 6'b111111);
    end

    $display("[TB] accept on last frame cycle, second offer while pending");
    wait_pwm(15);
    checkOutput("ready_at_max", in_ready, 1);
    in_valid   = 1'b1;
    in_pattern = 6'b111111;
    in_duty    = 4'd15;
    step(1);
    checkOutput("pending_after_max", in_ready, 0);
    in_pattern = 6'b000011;
    step(3);
    in_valid = 1'b0;
    checkOutput("late_frame_pwm3", led, 6'b000000);
    wait_pwm(8);
    checkOutput("late_not_immediate", led, 6'b111111);
    checkOutput("late_still_pending", in_ready, 0);
    wait_pwm(15);
    checkOutput("late_pending_end", in_ready, 0);
    step(1);
    checkOutput("late_applied_ready", in_ready, 1);
    wait_pwm(8);
    checkOutput("late_applied_led", led, 6'b000000);
    wait_pwm(1);
    checkOutput("second_not_taken_ready", in_ready, 1);
    wait_pwm(8);
    checkOutput("second_not_applied", led, 6'b000000);

    $display("[TB] blink on LED0");
    wait_pwm(4);
    applyStimulus(6'b000001, 4'd15, 1'b1, 1'b0);
    wait_pwm(1);
    for (int i = 0; i < 48; i++) begin
      checkOutput("blink_led", led, blink_phase_at(cyc - 1) ? 6'b111110 : 6'b111111);
      step(1);
    end

    $display("[TB] reset while pending");
    wait_pwm(2);
    applyStimulus(6'b111111, 4'd15, 1'b0, 1'b0);
    step(2);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_led", led, 6'b111111);
    checkOutput("async_rst_ready", in_ready, 1);
    checkOutput("async_rst_tick", frame_tick, 0);
    @(negedge clk);
    rst = 1'b0;
    step(17);
    checkOutput("shadow_gone_led", led, 6'b111111);
    checkOutput("shadow_gone_ready", in_ready, 1);
    step(8);
    checkOutput("shadow_gone_led2", led, 6'b111111);

`ifdef LED_DRV_BREATHE_EN
    $display("[TB] breathe ramp to duty 3");
    applyStimulus(6'b111111, 4'd3, 1'b0, 1'b1);
    wait_pwm(0);
    for (int f = 0; f < 8; f++) begin
      int lit_cnt;
      lit_cnt = 0;
      for (int i = 1; i <= 16; i++) begin
        step(1);
        if (led == 6'b000000) lit_cnt++;
      end
      checkOutput("breathe_frame", lit_cnt, bexp[f]);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
